// File: rtl/program_loader.sv
// UART boot loader: takes a little-endian word count followed by that many
// little-endian 32-bit words and writes them into instruction RAM, then releases the core.
module program_loader #(
  parameter int          MAX_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en_instr,
  output logic [31:0] addr_in_instr,
  output logic [31:0] data_in_instr,
  output logic        core_start,
  output logic        load_error,
  output logic [14:0] words_loaded
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERROR} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] n;
  logic [31:0] index;
  logic [31:0] word;
  logic [31:0] n_full;

  // Complete word count as it will look once the current (4th) header byte lands.
  assign n_full = {rx_data, n[23:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_cnt      <= 2'd0;
      n             <= 32'd0;
      index         <= 32'd0;
      word          <= 32'd0;
      wr_en_instr   <= 1'b0;
      addr_in_instr <= 32'd0;
      data_in_instr <= 32'd0;
      core_start    <= 1'b0;
      load_error    <= 1'b0;
      words_loaded  <= 15'd0;
    end else begin
      wr_en_instr   <= 1'b0;
      addr_in_instr <= 32'd0;
      data_in_instr <= 32'd0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            n        <= {24'd0, rx_data};
            byte_cnt <= 2'd1;
            state    <= LEN;
          end
        end
        LEN: begin
          if (rx_valid) begin
            n[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              index <= 32'd0;
              if (n_full == 32'd0) begin
                state      <= DONE;
                core_start <= 1'b1;
              end else if (n_full > 32'(MAX_WORDS)) begin
                state      <= ERROR;
                load_error <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          // The write cycle of the final word is the only place DATA can finish.
          if (wr_en_instr && index == n) begin
            state      <= DONE;
            core_start <= 1'b1;
          end else if (rx_valid) begin
            word[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en_instr   <= 1'b1;
              addr_in_instr <= BASE_ADDR + (index << 2);
              data_in_instr <= {rx_data, word[23:0]};
              index         <= index + 32'd1;
              words_loaded  <= words_loaded + 15'd1;
            end
          end
        end
        DONE:    ;
        ERROR:   ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
